decoder_16: RTL and testbench
=============================

Name: decoder_16

Overview:
- 4-to-16 one-hot decoder, the building block of the 32-entry decoder (two instances: lower half, upper half).
- The upper level gates the halves with sel[4] and its enable.
- `out` is purely combinational from `sel` and has no enable; the parent does all gating.
- A registered copy `out_q` (one clock, async active-low reset) is also provided for pipelined consumers.

Parameters:
- None. Width is fixed: 4 select bits, 16 outputs.

Ports:
- clk    input   1   clock; only the `out_q` register uses it.
- rst_n  input   1   asynchronous, active-low reset; only `out_q` uses it.
- sel    input   4   binary index of the output to assert.
- out    output  16  combinational one-hot decode of `sel`.
- out_q  output  16  `out` registered on the rising edge of clk.

Behaviour:
- Combinational path:
  - out[i] = 1 exactly when sel == i, for i = 0..15; all other bits are 0.
  - Zero-cycle latency, no clock dependence.
  - Bit 0 = sel 4'b0000; bit 15 = sel 4'b1111.
- Always exactly one bit of `out` is high for any known `sel`. There is no enable and no all-zero state on `out`.
- X/Z on any `sel` bit: the affected `out` bits may be X. No sanitising is required.
- Structure:
  - Two 2-to-4 predecoders: one on sel[1:0], one on sel[3:2].
  - out[4*j+k] = AND(hi[j], lo[k]).
  - Built from gate primitives (not/and); no behavioural case statements.
- Registered path:
  - On the rising edge of clk, out_q <= out.
  - While rst_n = 0, out_q = 16'h0000 immediately, without waiting for a clock edge.
  - After rst_n deasserts, out_q holds 0 until the first rising edge, then tracks `out` with 1-cycle latency.
- Reset has no effect on `out`.
- Reset asserted mid-operation clears out_q asynchronously in the same instant; `out` keeps decoding.
- out_q = 16'h0000 occurs only during or immediately after reset.
- Wrap-around: 4'hF -> 4'h0 moves the one-hot bit from bit 15 to bit 0 with no glitch requirement beyond settling within the cycle.

Decomposition:
- Shared package (decoder_pkg):
  - localparam SEL_W = 4.
  - localparam OUT_W = 16.
  - typedef logic [SEL_W-1:0] sel4_t.
  - typedef logic [OUT_W-1:0] onehot16_t.
- One sub-module, decoder_2to4:
  - Input sel[1:0], output out[3:0], gate-level.
  - Instantiated twice (low pair, high pair).
- The out_q register stays in the top module.

Test Plan:
- Exhaustive sweep: sel = 0..15, 10 ns apart; check out == 16'b1 << sel each step, plus $onehot(out).
  - Examples: sel=0 -> 16'h0001; sel=5 -> 16'h0020; sel=15 -> 16'h8000.
- Reset: rst_n=0 with sel=4'h7 -> out_q == 16'h0000 before any clk edge, out == 16'h0080. Release rst_n; after the first rising edge, out_q == 16'h0080.
- Latency: sel changes 3 -> 9 between edges -> out == 16'h0200 immediately; out_q == 16'h0008 until the next edge, then 16'h0200.
- Async reset mid-run: sel=4'hC, out_q == 16'h1000; drop rst_n between edges -> out_q == 16'h0000 without a clock; out stays 16'h1000.
- Wrap: sel 4'hF -> 4'h0 -> out goes 16'h8000 -> 16'h0001; out_q follows one cycle later.
- Integration: two instances plus gating by sel[4] and en; sweep 0..31 with en=1 -> single bit at index sel; sweep with en=0 -> all 32 outputs 0.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared widths and types for the one-hot select decoders.
package decoder_pkg;

    localparam int SEL_W = 4;
    localparam int OUT_W = 16;

    typedef logic [SEL_W-1:0] sel4_t;
    typedef logic [OUT_W-1:0] onehot16_t;

endpackage : decoder_pkg

// File: rtl/decoder_2to4.sv
// 2-to-4 one-hot predecoder built from gate primitives.
module decoder_2to4 (
    input  logic [1:0] sel,
    output logic [3:0] out
);

    wire [1:0] sel_n;
    wire [3:0] dec;

    not u_not0 (sel_n[0], sel[0]);
    not u_not1 (sel_n[1], sel[1]);

    and u_and0 (dec[0], sel_n[1], sel_n[0]);
    and u_and1 (dec[1], sel_n[1], sel[0]);
    and u_and2 (dec[2], sel[1],   sel_n[0]);
    and u_and3 (dec[3], sel[1],   sel[0]);

    // Bring the primitive outputs onto the port.
    assign out = dec;

endmodule : decoder_2to4

// File: rtl/decoder_16.sv
// 4-to-16 one-hot decoder: two 2-to-4 predecoders combined by an AND
// matrix, plus a registered copy for pipelined consumers. The combinational
// output has no enable; the parent gates halves when building wider decoders.
module decoder_16
    import decoder_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SEL_W-1:0] sel,
    output logic [OUT_W-1:0] out,
    output logic [OUT_W-1:0] out_q
);

    logic [3:0] lo;
    logic [3:0] hi;
    wire  [OUT_W-1:0] dec;

    decoder_2to4 u_pre_lo (
        .sel (sel[1:0]),
        .out (lo)
    );

    decoder_2to4 u_pre_hi (
        .sel (sel[3:2]),
        .out (hi)
    );

    // out[4*j+k] is high when the high pair selects j and the low pair selects k.
    for (genvar j = 0; j < 4; j++) begin : g_hi
        for (genvar k = 0; k < 4; k++) begin : g_lo
            and u_and (dec[4*j+k], hi[j], lo[k]);
        end
    end

    assign out = dec;

    // One-cycle registered copy of the decode; cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else begin
            out_q <= dec;
        end
    end

endmodule : decoder_16

// File: tb/tb_decoder_16.sv
// Self-checking bench for decoder_16, including a 32-entry integration
// built from two instances gated by sel[4] and an enable.
module tb_decoder_16;

    logic        clk;
    logic        rst_n;
    logic [3:0]  sel;
    logic [15:0] out;
    logic [15:0] out_q;

    logic [4:0]  sel5;
    logic        en;
    logic [15:0] lo_out, hi_out, lo_q, hi_q;
    logic [31:0] out32;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [15:0] exp_q[$];

    decoder_16 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sel   (sel),
        .out   (out),
        .out_q (out_q)
    );

    decoder_16 u_lo (
        .clk   (clk),
        .rst_n (rst_n),
        .sel   (sel5[3:0]),
        .out   (lo_out),
        .out_q (lo_q)
    );

    decoder_16 u_hi (
        .clk   (clk),
        .rst_n (rst_n),
        .sel   (sel5[3:0]),
        .out   (hi_out),
        .out_q (hi_q)
    );

    assign out32[15:0]  = lo_out & {16{en & ~sel5[4]}};
    assign out32[31:16] = hi_out & {16{en &  sel5[4]}};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Pop the next expected out_q from the scoreboard and compare.
    task automatic pop_check(input string name);
        logic [15:0] e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty, got %h", name, out_q);
        end else begin
            e = exp_q.pop_front();
            if (out_q !== e) begin
                n_fail++;
                $display("FAIL %s: out_q got %h, required %h", name, out_q, e);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sel   = 4'h7;
        sel5  = 5'd0;
        en    = 1'b0;
        #1;
        chk16("reset_out_q_no_edge", out_q, 16'h0000);
        chk16("reset_out", out, 16'h0080);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk16("reset_release_hold", out_q, 16'h0000);
        @(posedge clk); #1;
        chk16("reset_first_edge", out_q, 16'h0080);
    endtask

    task automatic test_sweep();
        logic [15:0] e;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            sel = 4'(i);
            e = 16'h0001 << i;
            exp_q.push_back(e);
            #1;
            chk16($sformatf("sweep_out_%0d", i), out, e);
            n_cmp++;
            if (!$onehot(out)) begin
                n_fail++;
                $display("FAIL sweep_onehot_%0d: got %h, required one hot", i, out);
            end
            @(posedge clk); #1;
            pop_check($sformatf("sweep_q_%0d", i));
        end
    endtask

    task automatic test_latency();
        @(negedge clk);
        sel = 4'h3;
        @(posedge clk); #1;
        chk16("lat_q_3", out_q, 16'h0008);
        @(negedge clk);
        sel = 4'h9;
        #1;
        chk16("lat_out_9", out, 16'h0200);
        chk16("lat_q_old", out_q, 16'h0008);
        @(posedge clk); #1;
        chk16("lat_q_9", out_q, 16'h0200);
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        sel = 4'hC;
        @(posedge clk); #1;
        chk16("arst_q_before", out_q, 16'h1000);
        #2;
        rst_n = 1'b0;
        #1;
        chk16("arst_q_cleared", out_q, 16'h0000);
        chk16("arst_out_kept", out, 16'h1000);
        @(posedge clk); #1;
        chk16("arst_q_held", out_q, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk16("arst_q_recover", out_q, 16'h1000);
    endtask

    task automatic test_wrap();
        @(negedge clk);
        sel = 4'hF;
        exp_q.push_back(16'h8000);
        #1;
        chk16("wrap_out_f", out, 16'h8000);
        @(posedge clk); #1;
        pop_check("wrap_q_f");
        @(negedge clk);
        sel = 4'h0;
        exp_q.push_back(16'h0001);
        #1;
        chk16("wrap_out_0", out, 16'h0001);
        chk16("wrap_q_lag", out_q, 16'h8000);
        @(posedge clk); #1;
        pop_check("wrap_q_0");
    endtask

    task automatic test_integration();
        logic [31:0] e;
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 32; i++) begin
                @(negedge clk);
                en   = (pass == 0);
                sel5 = 5'(i);
                e = (pass == 0) ? (32'h1 << i) : 32'h0;
                #1;
                n_cmp++;
                if (out32 !== e) begin
                    n_fail++;
                    $display("FAIL integ_en%0d_%0d: got %h, required %h", 1 - pass, i, out32, e);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_latency();
        test_async_reset();
        test_wrap();
        test_integration();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_decoder_16
